instr_fetch_unit: RTL and testbench

//  Producer side of the instruction-register load path. Sequences one instruction fetch per request:
//  - presents PC to memory and waits for read data;
//  - drives the fetched word onto the shared bus and pulses IRin so the instruction register captures it;
//  - then advances PC.

---
 rtl/instr_fetch_unit_pkg.sv | 24 ++
 rtl/instr_fetch_unit_pc_reg.sv | 38 +++
 rtl/instr_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding, default widths
// and the wait-counter sizing helper used by the FETCH_TIMEOUT_EN build.
package instr_fetch_unit_pkg;

    localparam int unsigned DEF_ADDR_W         = 9;
    localparam int unsigned DEF_DATA_W         = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 15;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_LOAD = 3'd3,
        S_DONE = 3'd4
    } fetch_state_e;

    // Wait counter never narrower than 4 bits, wide enough to reach the timeout.
    function automatic int unsigned wait_cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        return (w > 4) ? w : 4;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: synchronous reset, load and increment; a load wins over a same-cycle
// increment and the increment wraps modulo 2**ADDR_W.
module pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned        ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0]  PC_RESET = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_value_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_value_i;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: PC -> memory read -> bus/IRin load -> PC advance.
// Optional WAIT timeout abort is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned        ADDR_W         = DEF_ADDR_W,
    parameter int unsigned        DATA_W         = DEF_DATA_W,
    parameter logic [ADDR_W-1:0]  PC_RESET       = '0,
    parameter int unsigned        TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_loadvalue,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic [DATA_W-1:0] busdata,
    output logic              bus_drive,
    output logic              IRin,
    output logic [ADDR_W-1:0] pc_value,
    output logic              fetch_done,
    output logic              busy,
    output logic              fetch_error
);

    if (TIMEOUT_CYCLES == 0) begin : g_timeout_check
        $error("instr_fetch_unit: TIMEOUT_CYCLES must be at least 1");
    end

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] buf_q;
    logic              pc_inc;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .PC_RESET (PC_RESET)
    ) u_pc_reg (
        .clk_i        (clock),
        .rst_i        (reset),
        .load_i       (pc_load),
        .load_value_i (pc_loadvalue),
        .inc_i        (pc_inc),
        .pc_o         (pc_value)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = wait_cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout_hit;
    logic             fetch_error_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q    <= '0;
            fetch_error_q <= 1'b0;
        end else begin
            fetch_error_q <= timeout_hit;
            if (state_q == S_ADDR) begin
                wait_cnt_q <= '0;
            end else if (state_q == S_WAIT) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
        end
    end

    assign fetch_error = fetch_error_q;
`else
    assign fetch_error = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        mem_read   = 1'b0;
        bus_drive  = 1'b0;
        IRin       = 1'b0;
        fetch_done = 1'b0;
        pc_inc     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (fetch_start) state_d = S_ADDR;
            end
            S_ADDR: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_d = S_LOAD;
                end
`ifdef FETCH_TIMEOUT_EN
                // Counter holds the number of WAIT cycles already spent before this one.
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = S_IDLE;
                end
`endif
            end
            S_LOAD: begin
                bus_drive = 1'b1;
                IRin      = 1'b1;
                pc_inc    = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                fetch_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mem_addr_q <= '0;
            buf_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ADDR) begin
                mem_addr_q <= pc_value;
            end
            if (state_q == S_WAIT && mem_ready) begin
                buf_q <= mem_rdata;
            end
        end
    end

    assign mem_addr = mem_addr_q;
    assign busdata  = bus_drive ? buf_q : '0;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table-driven fetches with a scoreboard queue,
// plus hand sequences for idle noise, PC load, reset mid-fetch and (FETCH_TIMEOUT_EN) timeout.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TMO    = 15;

    logic              clock = 1'b0;
    logic              reset;
    logic              fetch_start;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_loadvalue;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic [DATA_W-1:0] busdata;
    logic              bus_drive;
    logic              IRin;
    logic [ADDR_W-1:0] pc_value;
    logic              fetch_done;
    logic              busy;
    logic              fetch_error;

    instr_fetch_unit #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .PC_RESET       (9'h000),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .fetch_start  (fetch_start),
        .pc_load      (pc_load),
        .pc_loadvalue (pc_loadvalue),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .busdata      (busdata),
        .bus_drive    (bus_drive),
        .IRin         (IRin),
        .pc_value     (pc_value),
        .fetch_done   (fetch_done),
        .busy         (busy),
        .fetch_error  (fetch_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic              ld;
        logic [ADDR_W-1:0] ldv;
        logic              mid_ld;
        logic [ADDR_W-1:0] mid_v;
        logic              hold_start;
        logic [DATA_W-1:0] rdata;
        int unsigned       waits;
        logic [ADDR_W-1:0] exp_addr;
        logic [ADDR_W-1:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] pc;
    } exp_t;

    vec_t        vecs[5];
    exp_t        sb[$];
    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_fetch(input int idx, input vec_t v);
        exp_t        e, got;
        int unsigned mr = 0, irn = 0, dn = 0, cyc = 0;
        int          ready_at = -10, ir_at = -1, dn_at = -1;
        bit          addr_bad = 0, bus_bad = 0, err_bad = 0, done = 0;
        string       p;
        p = $sformatf("v%0d", idx);
        e.addr = v.exp_addr;
        e.data = v.rdata;
        e.pc   = v.exp_pc;
        sb.push_back(e);
        got = e;

        fetch_start  = 1'b1;
        pc_load      = v.ld;
        pc_loadvalue = v.ldv;
        tick();
        fetch_start = v.hold_start;
        pc_load     = 1'b0;
        check({p, " addr_phase_busy"}, busy, 1);
        check({p, " addr_phase_mem_read"}, mem_read, 0);
        tick();
        if (v.mid_ld) begin
            pc_load      = 1'b1;
            pc_loadvalue = v.mid_v;
        end

        while (!done && cyc < 64) begin
            if (mem_read) begin
                mr++;
                if (mem_addr !== v.exp_addr) addr_bad = 1;
            end
            if (!bus_drive && busdata !== '0) bus_bad = 1;
            if (fetch_error !== 1'b0) err_bad = 1;
            if (IRin) begin
                irn++;
                ir_at = cyc;
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    check({p, " busdata"}, busdata, got.data);
                    check({p, " irin_addr"}, mem_addr, got.addr);
                    check({p, " bus_drive"}, bus_drive, 1);
                end else begin
                    check({p, " scoreboard_underflow"}, sb.size(), 1);
                end
            end
            if (fetch_done) begin
                dn++;
                dn_at = cyc;
                check({p, " pc_after"}, pc_value, got.pc);
                done        = 1;
                fetch_start = 1'b0;
                pc_load     = 1'b0;
            end
            mem_ready = mem_read && (mr == v.waits + 1);
            if (mem_ready) begin
                ready_at  = int'(cyc);
                mem_rdata = v.rdata;
            end else begin
                mem_rdata = $urandom;
            end
            cyc++;
            tick();
        end
        mem_ready = 1'b0;

        check({p, " completed"}, done, 1);
        check({p, " mem_read_cycles"}, mr, v.waits + 1);
        check({p, " irin_pulses"}, irn, 1);
        check({p, " done_pulses"}, dn, 1);
        check({p, " irin_latency"}, ir_at, ready_at + 1);
        check({p, " done_latency"}, dn_at, ready_at + 2);
        check({p, " mem_addr_stable"}, addr_bad, 0);
        check({p, " bus_idle_zero"}, bus_bad, 0);
        check({p, " no_fetch_error"}, err_bad, 0);
        check({p, " idle_after"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        int unsigned mr, errs;
        vecs[0] = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 32'hA5A5_0001, 0, 9'h000, 9'h001};
        vecs[1] = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 32'h1234_5678, 5, 9'h001, 9'h002};
        vecs[2] = '{1'b1, 9'h1FF, 1'b0, 9'h000, 1'b0, 32'hDEAD_BEEF, 1, 9'h1FF, 9'h000};
        vecs[3] = '{1'b1, 9'h003, 1'b1, 9'h040, 1'b0, 32'h0BAD_F00D, 2, 9'h003, 9'h040};
        vecs[4] = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 32'hCAFE_0042, 3, 9'h040, 9'h041};

        reset        = 1'b1;
        fetch_start  = 1'b0;
        pc_load      = 1'b0;
        pc_loadvalue = '0;
        mem_ready    = 1'b0;
        mem_rdata    = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst busy", busy, 0);
        check("rst mem_read", mem_read, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst pc_value", pc_value, 0);
        check("rst busdata", busdata, 0);
        check("rst irin_done", {IRin, fetch_done, bus_drive, fetch_error}, 0);

        for (int i = 0; i < 5; i++) begin
            run_fetch(i, vecs[i]);
        end

        // mem_ready while idle must not start anything
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        check("idle_ready busy", busy, 0);
        check("idle_ready irin", {IRin, mem_read}, 0);
        mem_ready = 1'b0;

        pc_load      = 1'b1;
        pc_loadvalue = 9'h0AB;
        tick();
        pc_load = 1'b0;
        check("idle_load pc", pc_value, 9'h0AB);
        check("idle_load busy", busy, 0);

        // reset while waiting for memory
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        check("rst_wait mem_read_before", mem_read, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_wait mem_read", mem_read, 0);
        check("rst_wait busy", busy, 0);
        check("rst_wait pc", pc_value, 0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (IRin || fetch_done || busy) seen = 1;
            mem_ready = 1'b1;
            tick();
        end
        mem_ready = 1'b0;
        check("rst_wait no_irin_done", seen, 0);

`ifdef FETCH_TIMEOUT_EN
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        mr   = 0;
        errs = 0;
        seen = 0;
        for (int i = 0; i < 40 && errs == 0; i++) begin
            if (mem_read) mr++;
            if (IRin || fetch_done) seen = 1;
            if (fetch_error) begin
                errs++;
                check("tmo idle_on_error", busy, 0);
            end else begin
                tick();
            end
        end
        check("tmo wait_cycles", mr, TMO);
        check("tmo error_seen", errs, 1);
        check("tmo no_irin", seen, 0);
        check("tmo pc_unchanged", pc_value, 0);
        tick();
        check("tmo error_pulse", fetch_error, 0);
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
